// File: rtl/tap_period.sv
// ---------------------------------------------------------------------------
// tap_period
//   Consumer end of the debounced button path in TapTempo. It measures the
//   time between successive rising edges of btn_i in tp_i ticks and emits
//   one period word per accepted tap. It raises a timeout strobe when the
//   user stops tapping.
//
// Ports
//   clk_i          system clock
//   rst_i          asynchronous, active-high reset
//   tp_i           time-pulse strobe, one clk_i cycle per tick
//   btn_i          debounced button level, synchronous to clk_i
//   period_o       last accepted period, or the 4-tap average (see below)
//   period_valid_o one-cycle strobe when period_o is updated
//   timeout_o      one-cycle strobe when the tapping sequence is abandoned
//   tapping_o      high while a reference tap is held (state s_count)
//
// Optional feature macro: TAP_AVERAGE_EN
//   When defined, period_o is the mean of the last four accepted periods.
//   The history is seeded with the first accepted period after idle or reset.
// ---------------------------------------------------------------------------
module tap_period #(
    parameter int CNT_WIDTH     = 20,
    parameter int MIN_TICKS     = 48_828,
    parameter int TIMEOUT_TICKS = 610_352
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 tp_i,
    input  logic                 btn_i,
    output logic [CNT_WIDTH-1:0] period_o,
    output logic                 period_valid_o,
    output logic                 timeout_o,
    output logic                 tapping_o
);

    localparam logic [CNT_WIDTH-1:0] MIN_C = CNT_WIDTH'(MIN_TICKS);
    localparam logic [CNT_WIDTH-1:0] TO_C  = CNT_WIDTH'(TIMEOUT_TICKS);

    typedef enum logic {s_idle, s_count} state_t;

    state_t                 state_q, state_d;
    logic                   btn_q;
    logic                   rise;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic                   accept;
    logic                   timeout_d;
    logic [CNT_WIDTH-1:0]   period_new;
    logic [CNT_WIDTH-1:0]   period_q;
    logic                   valid_q, timeout_q;

    // Rising-edge detector on the debounced level; release is ignored.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) btn_q <= 1'b0;
        else       btn_q <= btn_i;
    end
    assign rise = btn_i & ~btn_q;

    // ---- FSM: state register ----
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= s_idle;
        else       state_q <= state_d;
    end

    // ---- FSM: next state ----
    always_comb begin
        state_d = state_q;
        case (state_q)
            s_idle:  if (rise) state_d = s_count;
            // A rise that coincides with the timeout restarts the measurement.
            s_count: if (cnt_q == TO_C && !rise) state_d = s_idle;
            default: state_d = s_idle;
        endcase
    end

    // ---- FSM: outputs / datapath next values ----
    always_comb begin
        cnt_d     = cnt_q;
        accept    = 1'b0;
        timeout_d = 1'b0;
        case (state_q)
            s_idle: cnt_d = '0;
            s_count: begin
                if (cnt_q == TO_C) begin
                    timeout_d = 1'b1;
                    cnt_d     = '0;
                end else if (rise && cnt_q >= MIN_C) begin
                    // A coincident tp_i is dropped: the new interval starts at 0.
                    accept = 1'b1;
                    cnt_d  = '0;
                end else if (tp_i) begin
                    // Rejected double taps fall through here, so counting continues.
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: cnt_d = '0;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

`ifdef TAP_AVERAGE_EN
    // Newest entry is hist_q[0]. hist_full_q is low until the history is seeded.
    logic [3:0][CNT_WIDTH-1:0] hist_q;
    logic                      hist_full_q;
    logic [CNT_WIDTH+1:0]      sum;

    always_comb begin
        if (hist_full_q)
            sum = (CNT_WIDTH+2)'(cnt_q) + (CNT_WIDTH+2)'(hist_q[0])
                + (CNT_WIDTH+2)'(hist_q[1]) + (CNT_WIDTH+2)'(hist_q[2]);
        else
            sum = {cnt_q, 2'b00};
        period_new = sum[CNT_WIDTH+1:2];
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            hist_q      <= '0;
            hist_full_q <= 1'b0;
        end else if (accept) begin
            if (hist_full_q) hist_q <= {hist_q[2:0], cnt_q};
            else             hist_q <= {4{cnt_q}};
            hist_full_q <= 1'b1;
        end else if (timeout_d) begin
            hist_full_q <= 1'b0;
        end
    end
`else
    assign period_new = cnt_q;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            period_q  <= '0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            if (accept) period_q <= period_new;
            valid_q   <= accept;
            timeout_q <= timeout_d;
        end
    end

    assign period_o       = period_q;
    assign period_valid_o = valid_q;
    assign timeout_o      = timeout_q;
    assign tapping_o      = (state_q == s_count);

endmodule

// File: tb/tb_tap_period.sv
// Directed bench for tap_period: CNT_WIDTH=8, MIN_TICKS=10,
// TIMEOUT_TICKS=100, tp_i every 4th clock.
module tb_tap_period;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic       tp_i  = 1'b0;
    logic       btn_i = 1'b0;
    logic [7:0] period_o;
    logic       period_valid_o, timeout_o, tapping_o;

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;
    logic last_tp = 1'b0;

    tap_period #(.CNT_WIDTH(8), .MIN_TICKS(10), .TIMEOUT_TICKS(100)) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .tp_i           (tp_i),
        .btn_i          (btn_i),
        .period_o       (period_o),
        .period_valid_o (period_valid_o),
        .timeout_o      (timeout_o),
        .tapping_o      (tapping_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // One clock: remember what tp_i the edge sampled, then drive the next tp_i.
    task automatic step();
        last_tp = tp_i;
        @(posedge clk_i);
        #1;
        cyc++;
        tp_i = (cyc % 4 == 3);
    endtask

    // Advance until n ticks have been sampled; the next edge then sees tp_i=0.
    task automatic wait_tp(input int n);
        int got = 0;
        int guard = 0;
        while (got < n && guard < n * 4 + 16) begin
            step();
            if (last_tp) got++;
            guard++;
        end
        if (got < n) chk("wait_tp_bound", got, n);
    endtask

    // One-cycle press; captures outputs after the rise edge and one cycle later.
    task automatic press(output logic pv1, output int p1, output logic to1,
                         output logic tap1, output logic pv2, output logic to2);
        btn_i = 1'b1;
        step();
        pv1 = period_valid_o; p1 = period_o; to1 = timeout_o; tap1 = tapping_o;
        btn_i = 1'b0;
        step();
        pv2 = period_valid_o; to2 = timeout_o;
    endtask

    logic pv1, to1, tap1, pv2, to2;
    int   p1;
    int   exp_p2, exp_a3, exp_a4;

    initial begin
`ifdef TAP_AVERAGE_EN
        exp_p2 = 22;  // (30 + 20 + 20 + 20) >> 2
        exp_a3 = 25;  exp_a4 = 30;
`else
        exp_p2 = 30;
        exp_a3 = 40;  exp_a4 = 40;
`endif
        // Reset state
        step(); step();
        chk("rst_period", period_o, 0);
        chk("rst_valid", period_valid_o, 0);
        chk("rst_timeout", timeout_o, 0);
        chk("rst_tapping", tapping_o, 0);
        rst_i = 1'b0;
        wait_tp(1);

        // 1: first tap, then 20 ticks later
        press(pv1, p1, to1, tap1, pv2, to2);
        chk("t1_first_valid", pv1, 0);
        chk("t1_first_tapping", tap1, 1);
        wait_tp(20);
        press(pv1, p1, to1, tap1, pv2, to2);
        chk("t1_valid", pv1, 1);
        chk("t1_period", p1, 20);
        chk("t1_timeout", to1, 0);
        chk("t1_valid_drop", pv2, 0);

        // 2: 5-tick double tap rejected, next valid after 30 ticks total
        wait_tp(5);
        press(pv1, p1, to1, tap1, pv2, to2);
        chk("t2_reject_valid", pv1, 0);
        chk("t2_reject_valid2", pv2, 0);
        wait_tp(25);
        press(pv1, p1, to1, tap1, pv2, to2);
        chk("t2_valid", pv1, 1);
        chk("t2_period", p1, exp_p2);

        // 3: no press for 100 ticks -> timeout
        wait_tp(100);
        chk("t3_pre_timeout", timeout_o, 0);
        step();
        chk("t3_timeout", timeout_o, 1);
        chk("t3_tapping", tapping_o, 0);
        chk("t3_period_kept", period_o, exp_p2);
        chk("t3_valid", period_valid_o, 0);
        step();
        chk("t3_timeout_drop", timeout_o, 0);
        wait_tp(3);
        press(pv1, p1, to1, tap1, pv2, to2);
        chk("t3_first_valid", pv1, 0);
        chk("t3_first_tapping", tap1, 1);

        // 4: rise coincident with counter==100
        wait_tp(100);
        press(pv1, p1, to1, tap1, pv2, to2);
        chk("t4_timeout", to1, 1);
        chk("t4_valid", pv1, 0);
        chk("t4_tapping", tap1, 1);
        chk("t4_timeout_drop", to2, 0);
        wait_tp(25);
        press(pv1, p1, to1, tap1, pv2, to2);
        chk("t4_valid25", pv1, 1);
        chk("t4_period25", p1, 25);

        // 5: asynchronous reset mid-count
        wait_tp(40);
        rst_i = 1'b1;
        #2;
        chk("t5_rst_period", period_o, 0);
        chk("t5_rst_tapping", tapping_o, 0);
        step();
        rst_i = 1'b0;
        wait_tp(1);
        press(pv1, p1, to1, tap1, pv2, to2);
        chk("t5_first_valid", pv1, 0);
        chk("t5_first_tapping", tap1, 1);
        wait_tp(15);
        press(pv1, p1, to1, tap1, pv2, to2);
        chk("t5_period15", p1, 15);

        // 6: periods 20, 20, 40, 40 from a fresh reset
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        wait_tp(1);
        press(pv1, p1, to1, tap1, pv2, to2);
        wait_tp(20);
        press(pv1, p1, to1, tap1, pv2, to2);
        chk("t6_p1", p1, 20);
        wait_tp(20);
        press(pv1, p1, to1, tap1, pv2, to2);
        chk("t6_p2", p1, 20);
        wait_tp(40);
        press(pv1, p1, to1, tap1, pv2, to2);
        chk("t6_p3", p1, exp_a3);
        wait_tp(40);
        press(pv1, p1, to1, tap1, pv2, to2);
        chk("t6_p4", p1, exp_a4);
        chk("t6_valid", pv1, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
